pipelined_adder_nbits: RTL
==========================

Name: pipelined_adder_nbits

Overview:
- Parametrised, pipelined successor to the 4-bit fast-carry adder in the 74LSXX library.
- Splits a WIDTH-bit add/subtract into CHUNK-bit slices, one slice per pipeline stage, with the carry rippled stage to stage through registers.
- Uses a valid/ready handshake with global stall on backpressure.
- Feeds the digital-clock datapath and any wide counter/accumulator IP needing a clocked adder.

Parameters:
WIDTH, 16, operand width in bits; must be a multiple of CHUNK, WIDTH >= CHUNK.
CHUNK, 4, bits added per pipeline stage; STAGES = WIDTH/CHUNK.

Ports:
clk  in  1  rising-edge clock.
rst  in  1  asynchronous, active-high reset.
in_valid  in  1  operand word present.
in_ready  out  1  block can accept a word this cycle.
a  in  WIDTH  operand A.
b  in  WIDTH  operand B.
cin  in  1  carry-in; used only when sub=0.
sub  in  1  1 = subtract (A - B), 0 = add (A + B + cin).
out_valid  out  1  result present.
out_ready  in  1  downstream accepts the result.
sum  out  WIDTH  result.
cout  out  1  carry-out; for subtract, 1 = no borrow.
ovf  out  1  two's-complement signed overflow.

Behaviour:
- Reset (async assert, sync release):
  - All stage valid bits and data registers clear to 0.
  - out_valid=0, sum=0, cout=0, ovf=0.
  - in_ready=1 while rst is high and after release.
- Stall:
  - stall = out_valid & ~out_ready.
  - in_ready = ~stall (combinational).
  - When stall is high, every pipeline register holds its value.
  - An in_valid word offered during stall is not accepted.
- Transfer:
  - A word is accepted when in_valid & in_ready.
  - A result is consumed when out_valid & out_ready.
- Operand conditioning (at input):
  - Effective B = sub ? ~b : b.
  - Effective carry-in = sub ? 1 : cin.
- Stage k (0..STAGES-1):
  - Adds CHUNK slice k of A and effective B plus the carry registered by stage k-1 (effective carry-in for k=0).
  - Registers the slice sum and carry.
  - Already-computed lower slices travel forward unchanged.
  - Not-yet-used upper operand slices travel forward (skew buffers).
- Latency: exactly STAGES clock edges from acceptance to out_valid with no stall; each stall cycle adds one. Throughput is one word per cycle when out_ready=1.
- cout is the carry out of slice STAGES-1.
- ovf = (A[MSB] == Beff[MSB]) & (sum[MSB] != A[MSB]).
- Arithmetic is modulo 2^WIDTH; sum wraps on carry-out.
- Words leave in acceptance order; none are dropped or duplicated.
- Bubbles (in_valid=0) propagate as invalid stages.
- When out_valid is low, sum/cout/ovf hold their last values.
- Simultaneous accept and consume in one cycle is legal and keeps full throughput.
- Reset mid-operation discards all in-flight words. No output is produced for them.

Optional Feature:
Macro ADDER_BCD_EN.
- Defined:
  - Adds port "bcd in 1", carried alongside each word.
  - Elaboration error unless CHUNK==4.
  - With bcd=1, each stage applies decimal adjust: if raw nibble sum > 9 or a nibble carry occurs, add 6 and force the decimal carry to 1.
  - With bcd=1 and sub=1, effective B nibble = 9 - b nibble (nines' complement) and carry-in = 1, giving ten's-complement subtraction.
  - With bcd=1, cout is the decimal carry/no-borrow and ovf is forced to 0.
  - Non-BCD operand nibbles (>9) give unspecified sum but must not disturb the handshake.
- Undefined: bcd port absent; binary behaviour only.

Decomposition:
- Package adder_pkg:
  - Default CHUNK.
  - Function for stage count (WIDTH/CHUNK) with divisibility check.
  - BCD nibble-adjust function (used only under ADDER_BCD_EN).
  - Packed stage-register typedef: valid, carry, sum bits, pending A/B bits, bcd.
- One sub-module, adder_chunk_stage: one CHUNK-bit slice plus its register and stall hold, instantiated STAGES times by generate.

Test Plan:
1. WIDTH=16: a=16'h1234, b=16'h0FFF, cin=1, sub=0, out_ready=1 → out_valid exactly 4 cycles later; sum=16'h2234, cout=0, ovf=0.
2. Back-to-back: 0xFFFF+0x0001 then 0x7FFF+0x0001 on consecutive cycles → {sum=0x0000, cout=1, ovf=0}, then {sum=0x8000, cout=0, ovf=1}, on consecutive cycles, in order.
3. Subtract a=0x0003, b=0x0005, sub=1 → sum=0xFFFE, cout=0 (borrow), ovf=0.
4. Hold out_ready=0 for 3 cycles with 4 words streaming → in_ready=0 during stall, output held stable; after release, all 4 results emerge in order, none lost.
5. Assert rst with 3 words in flight → out_valid=0 and sum=0 immediately (async); no stale results after release.
6. ADDER_BCD_EN, bcd=1: a=16'h0958, b=16'h0047 → sum=16'h1005, cout=0. Then a=16'h0100, b=16'h0001, sub=1 → sum=16'h0099, cout=1.

Source files
------------

// File: rtl/adder_pkg.sv
// Shared types and helpers for the pipelined chunked adder.
// With ADDER_BCD_EN defined, the stage control word also carries the per-word decimal-mode flag.
package adder_pkg;

  localparam int unsigned CHUNK_DEF = 4;

  // Returns 0 when WIDTH is not a nonzero multiple of CHUNK, flagging a bad configuration.
  function automatic int unsigned num_stages(input int unsigned width, input int unsigned chunk);
    if (chunk == 0 || width < chunk || (width % chunk) != 0) return 0;
    return width / chunk;
  endfunction

  // Decimal adjust of one raw nibble sum {carry, nibble}: anything above 9 wraps by +6 and carries.
  function automatic logic [4:0] bcd_adjust(input logic [4:0] raw);
    logic [4:0] r;
    r = raw;
    if (raw > 5'd9) r = {1'b1, 4'(raw[3:0] + 4'd6)};
    return r;
  endfunction

  // Per-stage control; a_msb/b_msb ride along so overflow can be judged at the output.
  typedef struct packed {
    logic valid;
    logic carry;
    logic a_msb;
    logic b_msb;
`ifdef ADDER_BCD_EN
    logic bcd;
`endif
  } stage_ctl_t;

endpackage

// File: rtl/adder_chunk_stage.sv
// One CHUNK-bit slice of the pipelined adder plus its stage register with stall hold.
// The data word holds finished sum slices on top and interleaved {b,a} operand slices below.
module adder_chunk_stage
  import adder_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CHUNK = CHUNK_DEF,
  parameter int unsigned IDX   = 0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          stall,
  input  stage_ctl_t                    up_ctl,
  input  logic [2*WIDTH-IDX*CHUNK-1:0]  up_data,
  output stage_ctl_t                    ctl_q,
  output logic [2*WIDTH-IDX*CHUNK-CHUNK-1:0] data_q
);

  localparam int unsigned INW = 2*WIDTH - IDX*CHUNK;
  localparam int unsigned OW  = INW - CHUNK;

  logic [CHUNK:0]  raw;
  logic [CHUNK:0]  res;
  stage_ctl_t      ctl_d;
  logic [OW-1:0]   data_d;

  // Lowest slice pair is consumed; its sum is appended above the already finished slices.
  always_comb begin
    raw = {1'b0, up_data[CHUNK-1:0]} + {1'b0, up_data[2*CHUNK-1:CHUNK]} + (CHUNK+1)'(up_ctl.carry);
    res = raw;
`ifdef ADDER_BCD_EN
    if (up_ctl.bcd) res = (CHUNK+1)'(bcd_adjust(5'(raw)));
`endif
    ctl_d       = up_ctl;
    ctl_d.carry = res[CHUNK];
    data_d      = OW'({res[CHUNK-1:0], up_data} >> (2*CHUNK));
  end

  // Data only loads with a valid word so the output holds its last result across bubbles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctl_q  <= '0;
      data_q <= '0;
    end else if (!stall) begin
      if (up_ctl.valid) begin
        ctl_q  <= ctl_d;
        data_q <= data_d;
      end else begin
        ctl_q.valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/pipelined_adder_nbits.sv
// WIDTH-bit add/subtract pipelined as WIDTH/CHUNK carry-rippled stages with valid/ready stall.
// Optional decimal mode (adds the bcd port) is enabled by defining ADDER_BCD_EN.
module pipelined_adder_nbits
  import adder_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CHUNK = CHUNK_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
`ifdef ADDER_BCD_EN
  input  logic             bcd,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned STAGES = num_stages(WIDTH, CHUNK);

  if (STAGES == 0) begin : g_bad_width
    $error("pipelined_adder_nbits: WIDTH must be a nonzero multiple of CHUNK");
  end
`ifdef ADDER_BCD_EN
  if (CHUNK != 4) begin : g_bad_chunk
    $error("pipelined_adder_nbits: decimal mode needs CHUNK == 4");
  end
`endif

  logic               stall;
  logic [WIDTH-1:0]   beff;
  logic [2*WIDTH-1:0] word0;
  stage_ctl_t         ctl0;
  stage_ctl_t         last_ctl;

  // Operand conditioning and interleaving of {b,a} slices for the stage chain.
  always_comb begin
    beff = sub ? ~b : b;
`ifdef ADDER_BCD_EN
    if (bcd && sub) begin
      for (int n = 0; n < int'(STAGES); n++)
        beff[n*CHUNK +: CHUNK] = CHUNK'(CHUNK'(9) - b[n*CHUNK +: CHUNK]);
    end
`endif
    word0 = '0;
    for (int n = 0; n < int'(STAGES); n++) begin
      word0[2*n*CHUNK +: CHUNK]     = a[n*CHUNK +: CHUNK];
      word0[(2*n+1)*CHUNK +: CHUNK] = beff[n*CHUNK +: CHUNK];
    end
    ctl0       = '0;
    ctl0.valid = in_valid;
    ctl0.carry = sub | cin;
    ctl0.a_msb = a[WIDTH-1];
    ctl0.b_msb = beff[WIDTH-1];
`ifdef ADDER_BCD_EN
    ctl0.bcd   = bcd;
`endif
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_st
    localparam int unsigned INW = 2*WIDTH - k*CHUNK;
    stage_ctl_t            up_ctl;
    stage_ctl_t            ctl_q;
    logic [INW-1:0]        up_data;
    logic [INW-CHUNK-1:0]  data_q;

    if (k == 0) begin : g_head
      assign up_ctl  = ctl0;
      assign up_data = word0;
    end else begin : g_link
      assign up_ctl  = g_st[k-1].ctl_q;
      assign up_data = g_st[k-1].data_q;
    end

    adder_chunk_stage #(.WIDTH(WIDTH), .CHUNK(CHUNK), .IDX(k)) u_stage (
      .clk     (clk),
      .rst     (rst),
      .stall   (stall),
      .up_ctl  (up_ctl),
      .up_data (up_data),
      .ctl_q   (ctl_q),
      .data_q  (data_q)
    );
  end

  assign last_ctl  = g_st[STAGES-1].ctl_q;
  assign sum       = g_st[STAGES-1].data_q;
  assign out_valid = last_ctl.valid;
  assign cout      = last_ctl.carry;
  assign stall     = last_ctl.valid & ~out_ready;
  assign in_ready  = ~stall;

`ifdef ADDER_BCD_EN
  assign ovf = ~last_ctl.bcd & (last_ctl.a_msb == last_ctl.b_msb) & (sum[WIDTH-1] != last_ctl.a_msb);
`else
  assign ovf = (last_ctl.a_msb == last_ctl.b_msb) & (sum[WIDTH-1] != last_ctl.a_msb);
`endif

endmodule
